// File: rtl/warp_issue_arbiter_pkg.sv
// Shared warp-issue types: warp count, id width and the packed ibuf head entry.
package warp_issue_arbiter_pkg;
  localparam int NUM_WARPS    = 8;
  localparam int WARP_ID_BITS = $clog2(NUM_WARPS);

  typedef struct packed {
    logic [31:0]             pc;
    logic [WARP_ID_BITS-1:0] wid;
    logic [6:0]              op;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rs3;
    logic [31:0]             imm32;
    logic [23:0]             imm24;
    logic [2:0]              f3;
    logic [6:0]              f7;
  } ibuf_entry_t;

  localparam int PAYLOAD_BITS = $bits(ibuf_entry_t);
endpackage

// File: rtl/warp_issue_arbiter_if.sv
// Bundle between the ibuf heads, the issue port and the retire/credit path.
interface warp_issue_arbiter_if #(
  parameter int NUM_WARPS    = warp_issue_arbiter_pkg::NUM_WARPS,
  parameter int PAYLOAD_BITS = warp_issue_arbiter_pkg::PAYLOAD_BITS,
  parameter int WARP_ID_BITS = $clog2(NUM_WARPS)
);
  logic [NUM_WARPS-1:0]              ibuf_valid;
  logic [NUM_WARPS-1:0]              ibuf_ready;
  logic [NUM_WARPS*PAYLOAD_BITS-1:0] ibuf_payload;
  logic [NUM_WARPS-1:0]              warp_stall;
  logic                              issue_valid;
  logic                              issue_ready;
  logic [WARP_ID_BITS-1:0]           issue_wid;
  logic [PAYLOAD_BITS-1:0]           issue_payload;
  logic                              retire_valid;
  logic [WARP_ID_BITS-1:0]           retire_wid;
  logic [NUM_WARPS-1:0]              warp_busy;
  logic                              idle;
  logic                              credit_err;

  modport master (
    input  ibuf_valid, ibuf_payload, warp_stall, issue_ready, retire_valid, retire_wid,
    output ibuf_ready, issue_valid, issue_wid, issue_payload, warp_busy, idle, credit_err
  );

  modport slave (
    output ibuf_valid, ibuf_payload, warp_stall, issue_ready, retire_valid, retire_wid,
    input  ibuf_ready, issue_valid, issue_wid, issue_payload, warp_busy, idle, credit_err
  );
endinterface

// File: rtl/warp_issue_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [2*N-1:0] keep;
  logic [2*N-1:0] dbl;

  // The upper copy of req supplies the wrapped-around candidates below ptr.
  always_comb begin
    keep = ~(((2*N)'(1) << ptr) - (2*N)'(1));
    dbl  = {req, req} & keep;
    any  = 1'b0;
    idx  = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        any = 1'b1;
        idx = (i >= N) ? IW'(i - N) : IW'(i);
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/warp_issue_arbiter.sv
// Round-robin warp issue with a one-entry issue register and per-warp in-flight credits.
module warp_issue_arbiter #(
  parameter int NUM_WARPS    = warp_issue_arbiter_pkg::NUM_WARPS,
  parameter int PAYLOAD_BITS = warp_issue_arbiter_pkg::PAYLOAD_BITS,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                  clock,
  input logic                  reset,
  warp_issue_arbiter_if.master bus
);
  import warp_issue_arbiter_pkg::*;

  localparam int WARP_ID_BITS = $clog2(NUM_WARPS);
  localparam int CNT_BITS     = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_WARPS-1:0]    elig;
  logic [NUM_WARPS-1:0]    gnt;
  logic [NUM_WARPS-1:0]    busy;
  logic [WARP_ID_BITS-1:0] rr_ptr;
  logic [WARP_ID_BITS-1:0] gidx;
  logic                    any;
  logic                    load;
  logic                    hs;
  logic                    err_now;
  logic [PAYLOAD_BITS-1:0] gnt_payload;
  logic [CNT_BITS-1:0]     inflight [NUM_WARPS];

  assign load = ~bus.issue_valid | bus.issue_ready;
  assign hs   = load & any;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic ret;

    assign elig[w] = bus.ibuf_valid[w] & ~bus.warp_stall[w] &
                     (inflight[w] < CNT_BITS'(MAX_INFLIGHT));
    assign busy[w] = inflight[w] != '0;
    assign ret     = bus.retire_valid & (bus.retire_wid == WARP_ID_BITS'(w)) & busy[w];

    // Issue and retire on the same edge cancel out.
    always_ff @(posedge clock) begin
      if (reset)
        inflight[w] <= '0;
      else if (bus.ibuf_ready[w] & ~ret)
        inflight[w] <= inflight[w] + CNT_BITS'(1);
      else if (~bus.ibuf_ready[w] & ret)
        inflight[w] <= inflight[w] - CNT_BITS'(1);
    end
  end

  rr_arbiter #(.N(NUM_WARPS)) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign bus.ibuf_ready = load ? gnt : '0;
  assign bus.warp_busy  = busy;
  assign bus.idle       = ~bus.issue_valid & ~|busy;

  always_comb begin
    gnt_payload = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      if (gidx == WARP_ID_BITS'(w))
        gnt_payload = bus.ibuf_payload[w*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // Any retire not matched by a live credit (zero count or out-of-range id) is an error.
  always_comb begin
    err_now = bus.retire_valid;
    for (int w = 0; w < NUM_WARPS; w++)
      if (bus.retire_wid == WARP_ID_BITS'(w) && busy[w])
        err_now = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.issue_valid   <= 1'b0;
      bus.issue_wid     <= '0;
      bus.issue_payload <= '0;
      rr_ptr            <= '0;
      bus.credit_err    <= 1'b0;
    end else begin
      if (hs) begin
        bus.issue_valid   <= 1'b1;
        bus.issue_wid     <= gidx;
        bus.issue_payload <= gnt_payload;
        rr_ptr            <= (gidx == WARP_ID_BITS'(NUM_WARPS - 1)) ? '0 : gidx + WARP_ID_BITS'(1);
      end else if (bus.issue_ready) begin
        bus.issue_valid <= 1'b0;
      end
      if (err_now)
        bus.credit_err <= 1'b1;
    end
  end
endmodule
